// File: rtl/regfile_pkg.sv
// Shared constants and types for the multiport register file and its read ports.
package regfile_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 3;

  // A read port is either presenting a fresh result this cycle or idle.
  typedef enum logic {
    RP_IDLE  = 1'b0,
    RP_VALID = 1'b1
  } rport_state_e;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] data;
    logic                  valid;
    logic                  busy;
  } rport_t;

endpackage

// File: rtl/rf_read_port.sv
// One registered read port: write-first bypass, zero-entry masking, and output registers.
module rf_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] raddr_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              busy_nxt_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rvalid_o,
  output logic              rbusy_o
);

  rport_state_e      state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              rbusy_q, rbusy_d;
  logic              bypass_hit;
  logic              zero_hit;

  assign bypass_hit = we_i && (waddr_i == raddr_i);
  assign zero_hit   = (ZERO_REG != 0) && (raddr_i == '0);

  // Idle cycles hold the last data and busy flag; only the valid pulse drops.
  always_comb begin
    state_d = RP_IDLE;
    data_d  = data_q;
    rbusy_d = rbusy_q;
    if (rd_en_i) begin
      state_d = RP_VALID;
      data_d  = bypass_hit ? wdata_i : mem_rdata_i;
      rbusy_d = busy_nxt_i;
      if (zero_hit) begin
        data_d  = '0;
        rbusy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RP_IDLE;
      data_q  <= '0;
      rbusy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rbusy_q <= rbusy_d;
    end
  end

  assign rdata_o  = data_q;
  assign rvalid_o = (state_q == RP_VALID);
  assign rbusy_o  = rbusy_q;

endmodule

// File: rtl/multiport_register_file.sv
// 2-read/1-write register file with per-entry pending bits and optional hard-wired zero entry.
module multiport_register_file
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [ADDR_W-1:0]    waddr,
  input  logic [DATA_W-1:0]    wdata,
  input  logic                 rsv_en,
  input  logic [ADDR_W-1:0]    rsv_addr,
  input  logic                 rd_en_a,
  input  logic                 rd_en_b,
  input  logic [ADDR_W-1:0]    raddr_a,
  input  logic [ADDR_W-1:0]    raddr_b,
  output logic [DATA_W-1:0]    rdata_a,
  output logic [DATA_W-1:0]    rdata_b,
  output logic                 rvalid_a,
  output logic                 rvalid_b,
  output logic                 rbusy_a,
  output logic                 rbusy_b,
  output logic [2**ADDR_W-1:0] busy
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic              wr_ok;
  logic              rsv_ok;

  assign wr_ok  = we     && !((ZERO_REG != 0) && (waddr == '0));
  assign rsv_ok = rsv_en && !((ZERO_REG != 0) && (rsv_addr == '0));

  // Reserve is applied after the write so a same-cycle reservation keeps the entry pending.
  always_comb begin
    busy_d = busy_q;
    if (wr_ok)  busy_d[waddr]    = 1'b0;
    if (rsv_ok) busy_d[rsv_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      busy_q <= '0;
    end else begin
      if (wr_ok) mem_q[waddr] <= wdata;
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

  rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_port_a (
    .clk         (clk),
    .reset       (reset),
    .rd_en_i     (rd_en_a),
    .raddr_i     (raddr_a),
    .mem_rdata_i (mem_q[raddr_a]),
    .busy_nxt_i  (busy_d[raddr_a]),
    .we_i        (we),
    .waddr_i     (waddr),
    .wdata_i     (wdata),
    .rdata_o     (rdata_a),
    .rvalid_o    (rvalid_a),
    .rbusy_o     (rbusy_a)
  );

  rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_port_b (
    .clk         (clk),
    .reset       (reset),
    .rd_en_i     (rd_en_b),
    .raddr_i     (raddr_b),
    .mem_rdata_i (mem_q[raddr_b]),
    .busy_nxt_i  (busy_d[raddr_b]),
    .we_i        (we),
    .waddr_i     (waddr),
    .wdata_i     (wdata),
    .rdata_o     (rdata_b),
    .rvalid_o    (rvalid_b),
    .rbusy_o     (rbusy_b)
  );

endmodule

// File: doc/multiport_register_file.md
# multiport_register_file

Parametrised 2-read/1-write register file with a per-entry pending (scoreboard) bit. It generalises the 8×8 single-port register file for the datapath: width and depth are parameters, the design is fully synchronous on one clock, and the two independent read ports are registered with write-first bypass. An optional hard-wired zero entry is supported. The block sits between decode (reserve, read) and writeback (write) in the CPU datapath.

## Interface
- DATA_W, 8, entry width in bits
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W entries
- ZERO_REG, 0, if 1, entry 0 always reads 0; writes and reserves to it are ignored

- clk  in  1  single clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high; priority over every other input
- we  in  1  write enable
- waddr  in  ADDR_W  write address
- wdata  in  DATA_W  write data
- rsv_en  in  1  reserve enable; sets the pending bit of rsv_addr
- rsv_addr  in  ADDR_W  entry to reserve
- rd_en_a, rd_en_b  in  1  read request per port
- raddr_a, raddr_b  in  ADDR_W  read address per port
- rdata_a, rdata_b  out  DATA_W  read data, registered
- rvalid_a, rvalid_b  out  1  one-cycle pulse, rdata valid
- rbusy_a, rbusy_b  out  1  pending bit of the addressed entry at read time, registered with rdata
- busy  out  DEPTH  live pending vector, one bit per entry

## Operation
- Reset (clk edge with reset=1):
  - All entries, busy, rdata_*, rvalid_* and rbusy_* go to 0.
  - we, rsv_en and rd_en_* in the same cycle are discarded.
- Write: on an edge with we=1, mem[waddr] <= wdata and busy[waddr] <= 0.
- Reserve: on an edge with rsv_en=1, busy[rsv_addr] <= 1.
- Write and reserve to the same entry in the same cycle:
  - The data is written.
  - busy stays 1, because the new reservation wins.
- Reads: each port is independent. On an edge with rd_en_x=1:
  - rdata_x <= mem[raddr_x], or wdata if we=1 and waddr==raddr_x (write-first bypass).
  - rbusy_x <= busy[raddr_x] after applying the same-cycle write/reserve rules.
  - rvalid_x <= 1.
- When rd_en_x=0:
  - rvalid_x <= 0.
  - rdata_x and rbusy_x hold their last values.
- Both ports may read the same address in the same cycle; both get identical results.
- ZERO_REG=1:
  - Writes and reserves to address 0 are no-ops.
  - busy[0] is constantly 0.
  - Reads of address 0 return rdata=0 and rbusy=0, including when the bypass address matches.
- Out-of-range addresses cannot occur, since DEPTH = 2**ADDR_W.
- No internal FSM beyond the storage and pending bits. Each read port has two states, IDLE and VALID, selected by rd_en each cycle.

## Timing
- Write latency: 1 cycle. A read issued on the cycle after a write sees the new value in mem.
- A read issued in the same cycle as the write sees it via bypass.
- Read latency: 1 cycle, from rd_en sampled at edge N to rdata/rvalid valid after edge N, usable in cycle N+1.
- busy output: reflects state after the last edge, with no combinational path from inputs.
- Reset mid-stream: a read requested in the reset cycle produces no rvalid. The first valid read after deassertion returns 0.
- Back-to-back reads every cycle are supported on both ports; throughput is 1 read per port per cycle.

## Structure
- Package regfile_pkg holds:
  - Default DATA_W and ADDR_W constants.
  - A typedef for the read-port output bundle (data, valid, busy).
- Sub-module rf_read_port, instantiated twice, contains:
  - Address compare for bypass.
  - Zero-register masking.
  - Output registers.
- The top level holds the storage array, the busy vector, and the write/reserve logic.

## Test plan
- Reset then read: assert reset 2 cycles, then read A=3, B=7 -> rvalid_a=rvalid_b=1, rdata 0x00, rbusy 0.
- Write then read: write 0xA5 to 5, next cycle read A=5 -> rdata_a=0xA5 one cycle later, rbusy_a=0.
- Bypass: same cycle we=1 waddr=2 wdata=0x3C, rd A=2 B=2 -> both rdata=0x3C on the next cycle; old contents never appear.
- Scoreboard:
  - Reserve 4 -> busy[4]=1.
  - Read 4 -> rbusy_a=1.
  - Write 0x11 to 4 -> busy[4]=0.
  - Write to 4 plus reserve 4 in one cycle -> data 0x11 stored, busy[4]=1.
- ZERO_REG=1:
  - Write 0xFF to 0 and reserve 0, then read 0 -> rdata=0x00, rbusy=0, busy[0]=0.
  - Same sequence on entry 1 -> 0xFF stored, busy[1]=1.
- Reset mid-operation:
  - Fill all 8 entries, reserve 6.
  - Assert reset with rd_en_a=1 -> no rvalid that cycle.
  - Subsequent reads of every entry return 0, and busy=0.
